// File: rtl/mem_responder_pkg.sv
// mem_responder_pkg: FSM encoding, error pattern and delay helper shared by the responder.
package mem_responder_pkg;
    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;
    localparam logic [31:0] ERR_DATA = 32'hDEAD_BEEF;
    // Random delays use only the low three LFSR bits, so they span 0..7.
    function automatic logic [3:0] lfsr_delay(input logic [7:0] s);
        return {1'b0, s[2:0]};
    endfunction
endpackage

// File: rtl/mem_responder_if.sv
// mem_responder_if: request/response bus between a requester and the memory responder.
interface mem_responder_if;
    logic [31:0] addr;
    logic valid;
    logic wen;
    logic [31:0] wdata;
    logic [3:0] wmask;
    logic ready;
    logic [31:0] rdata;
    logic err;
    modport master (output addr, valid, wen, wdata, wmask, input ready, rdata, err);
    modport slave (input addr, valid, wen, wdata, wmask, output ready, rdata, err);
endinterface

// File: rtl/mem_responder_lfsr.sv
// delay_lfsr: 8-bit Fibonacci LFSR (x^8+x^6+x^5+x^4+1) used to draw response delays.
module delay_lfsr #(
    parameter logic [7:0] SEED = 8'hA5
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    output logic [7:0] state
);
    always_ff @(posedge clk)
        if (rst) state <= SEED;
        else if (en) state <= {state[6:0], state[7] ^ state[5] ^ state[4] ^ state[3]};
endmodule

// File: rtl/mem_responder.sv
// mem_responder: word-addressed memory model answering one request at a time after a fixed or random delay.
module mem_responder
    import mem_responder_pkg::*;
#(
    parameter int DEPTH_WORDS = 1024,
    parameter logic [31:0] BASE_ADDR = 32'h8000_0000,
    parameter int DELAY_MODE = 0,
    parameter int FIX_DELAY = 1,
    parameter logic [7:0] LFSR_SEED = 8'hA5
) (
    input logic clk,
    input logic rst,
    mem_responder_if.slave bus
);
    localparam int AW = DEPTH_WORDS > 1 ? $clog2(DEPTH_WORDS) : 1;
    state_t state, next_state;
    logic [3:0] cnt, next_cnt, delay;
    logic [7:0] lfsr;
    logic [31:0] addr_q, wdata_q, idx;
    logic [3:0] wmask_q;
    logic wen_q, oor, resp;
    logic [31:0] mem [DEPTH_WORDS];

    delay_lfsr #(.SEED(LFSR_SEED)) u_lfsr (.clk(clk), .rst(rst), .en(1'b1), .state(lfsr));

    assign delay = DELAY_MODE != 0 ? lfsr_delay(lfsr) : 4'(FIX_DELAY);
    assign idx = (addr_q - BASE_ADDR) >> 2;
    assign oor = addr_q < BASE_ADDR || idx >= 32'(DEPTH_WORDS);
    assign resp = state == RESP && !rst;

    always_ff @(posedge clk)
        if (rst) begin
            state <= IDLE;
            cnt <= '0;
        end else begin
            state <= next_state;
            cnt <= next_cnt;
        end

    always_comb begin
        next_state = state;
        next_cnt = cnt;
        if (state == IDLE && bus.valid) begin
            next_cnt = delay;
            next_state = delay == 4'd0 ? RESP : WAIT;
        end else if (state == WAIT) begin
            next_cnt = cnt - 4'd1;
            next_state = cnt == 4'd1 ? RESP : WAIT;
        end else if (state == RESP)
            next_state = IDLE;
    end

    // The request is captured once; the requester may change its outputs freely afterwards.
    always_ff @(posedge clk)
        if (!rst && state == IDLE && bus.valid) begin
            addr_q <= bus.addr;
            wen_q <= bus.wen;
            wdata_q <= bus.wdata;
            wmask_q <= bus.wmask;
        end

    always_ff @(posedge clk)
        if (resp && wen_q && !oor)
            for (int i = 0; i < 4; i++)
                if (wmask_q[i]) mem[idx[AW-1:0]][8*i +: 8] <= wdata_q[8*i +: 8];

    assign bus.ready = resp;
    assign bus.err = resp && oor;
    assign bus.rdata = !resp ? '0 : oor ? ERR_DATA : wen_q ? '0 : mem[idx[AW-1:0]];
endmodule

// File: tb/tb_mem_responder.sv
// tb_mem_responder: four responder configurations driven by directed and random requests against a scoreboard.
module tb_mem_responder;
    localparam logic [31:0] BASE = 32'h8000_0000;
    localparam logic [31:0] BEEF = 32'hDEAD_BEEF;
    logic clk = 0, rst = 1;
    logic [31:0] addr = 0, wdata = 0;
    logic wen = 0, valid = 0;
    logic [3:0] wmask = 0;
    int sel = 0, ecount = 0, vectors = 0, miscompares = 0;
    logic ready_o, err_o;
    logic [31:0] rdata_o;

    mem_responder_if b0(), b1(), b2(), b3();
    assign b0.addr = addr; assign b0.wen = wen; assign b0.wdata = wdata; assign b0.wmask = wmask; assign b0.valid = valid && sel == 0;
    assign b1.addr = addr; assign b1.wen = wen; assign b1.wdata = wdata; assign b1.wmask = wmask; assign b1.valid = valid && sel == 1;
    assign b2.addr = addr; assign b2.wen = wen; assign b2.wdata = wdata; assign b2.wmask = wmask; assign b2.valid = valid && sel == 2;
    assign b3.addr = addr; assign b3.wen = wen; assign b3.wdata = wdata; assign b3.wmask = wmask; assign b3.valid = valid && sel == 3;

    mem_responder #(.DELAY_MODE(0), .FIX_DELAY(2)) u0 (.clk(clk), .rst(rst), .bus(b0));
    mem_responder #(.DELAY_MODE(0), .FIX_DELAY(0)) u1 (.clk(clk), .rst(rst), .bus(b1));
    mem_responder #(.DELAY_MODE(0), .FIX_DELAY(5)) u2 (.clk(clk), .rst(rst), .bus(b2));
    mem_responder #(.DELAY_MODE(1), .LFSR_SEED(8'hA5)) u3 (.clk(clk), .rst(rst), .bus(b3));

    always_comb begin
        ready_o = sel == 0 ? b0.ready : sel == 1 ? b1.ready : sel == 2 ? b2.ready : b3.ready;
        err_o = sel == 0 ? b0.err : sel == 1 ? b1.err : sel == 2 ? b2.err : b3.err;
        rdata_o = sel == 0 ? b0.rdata : sel == 1 ? b1.rdata : sel == 2 ? b2.rdata : b3.rdata;
    end

    always #5 clk = ~clk;
    // Edges seen since the last reset edge; the free-running LFSR has advanced one step per such edge.
    always @(posedge clk) ecount <= rst ? 0 : ecount + 1;

    function automatic logic [7:0] lfsr_at(int k);
        logic [7:0] s = 8'hA5;
        for (int i = 0; i < k; i++) s = {s[6:0], ^(s & 8'hB8)};
        return s;
    endfunction

    // One request: lat is the number of cycles from the sampling edge to the ready cycle (-1 on timeout),
    // n the LFSR step count at the sampling edge, leak set if any output is nonzero outside the ready cycle.
    task automatic xact(input logic [31:0] a, input logic w, input logic [31:0] d, input logic [3:0] m,
                        output logic [31:0] rd, output logic er, output int lat, output int n, output logic leak);
        lat = -1; leak = 0; rd = 0; er = 0;
        @(negedge clk);
        addr = a; wen = w; wdata = d; wmask = m; valid = 1;
        @(posedge clk); #1;
        n = ecount - 1;
        valid = 0; addr = $urandom; wdata = $urandom; wen = ~w; wmask = 4'($urandom);
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk);
            if (ready_o) begin lat = i; rd = rdata_o; er = err_o; break; end
            if (rdata_o !== 0 || err_o !== 0) leak = 1;
        end
        if (lat > 0) begin
            @(negedge clk);
            if (ready_o !== 0 || rdata_o !== 0 || err_o !== 0) leak = 1;
        end
    endtask

    task automatic test_reset();
        int lat = -1;
        logic [31:0] rd = 0;
        logic er = 0;
        sel = 0; rst = 1; addr = BASE - 4; wen = 0; valid = 1;
        repeat (3) begin
            @(negedge clk);
            vectors++; if ({ready_o, err_o, rdata_o} !== 34'h0) begin miscompares++; $display("FAIL reset_outputs got %b/%b/%h want 0/0/0", ready_o, err_o, rdata_o); end
        end
        rst = 0;
        @(posedge clk); #1 valid = 0;
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk);
            if (ready_o) begin lat = i; rd = rdata_o; er = err_o; break; end
        end
        vectors++; if (lat !== 3) begin miscompares++; $display("FAIL reset_first_req_lat got %0d want 3", lat); end
        vectors++; if ({er, rd} !== {1'b1, BEEF}) begin miscompares++; $display("FAIL reset_first_req_resp got %b/%h want 1/%h", er, rd, BEEF); end
    endtask

    task automatic test_fixed();
        logic [31:0] rd; logic er, leak; int lat, n;
        sel = 0;
        xact(BASE + 32'h10, 1, 32'h1234_5678, 4'hF, rd, er, lat, n, leak);
        vectors++; if (lat !== 3) begin miscompares++; $display("FAIL fixed_wr_lat got %0d want 3", lat); end
        vectors++; if ({er, rd} !== 33'h0) begin miscompares++; $display("FAIL fixed_wr_resp got %b/%h want 0/0", er, rd); end
        vectors++; if (leak !== 0) begin miscompares++; $display("FAIL fixed_wr_quiet got %b want 0", leak); end
        xact(BASE + 32'h10, 0, 32'h0, 4'h0, rd, er, lat, n, leak);
        vectors++; if (lat !== 3) begin miscompares++; $display("FAIL fixed_rd_lat got %0d want 3", lat); end
        vectors++; if ({er, rd} !== {1'b0, 32'h1234_5678}) begin miscompares++; $display("FAIL fixed_rd_resp got %b/%h want 0/12345678", er, rd); end
        vectors++; if (leak !== 0) begin miscompares++; $display("FAIL fixed_rd_quiet got %b want 0", leak); end
    endtask

    task automatic test_byte_mask();
        logic [31:0] rd; logic er, leak; int lat, n;
        sel = 0;
        xact(BASE + 32'h10, 1, 32'hAABB_CCDD, 4'b0101, rd, er, lat, n, leak);
        vectors++; if ({lat, er, rd} !== {32'd3, 1'b0, 32'h0}) begin miscompares++; $display("FAIL mask_wr got lat %0d %b/%h want 3 0/0", lat, er, rd); end
        xact(BASE + 32'h10, 0, 32'h0, 4'h0, rd, er, lat, n, leak);
        vectors++; if ({er, rd} !== {1'b0, 32'h12BB_56DD}) begin miscompares++; $display("FAIL mask_rd got %b/%h want 0/12bb56dd", er, rd); end
        xact(BASE + 32'h10, 1, 32'hFFFF_FFFF, 4'b0000, rd, er, lat, n, leak);
        vectors++; if ({lat, er, rd} !== {32'd3, 1'b0, 32'h0}) begin miscompares++; $display("FAIL mask_none_wr got lat %0d %b/%h want 3 0/0", lat, er, rd); end
        xact(BASE + 32'h13, 0, 32'h0, 4'h0, rd, er, lat, n, leak);
        vectors++; if ({er, rd} !== {1'b0, 32'h12BB_56DD}) begin miscompares++; $display("FAIL mask_none_rd got %b/%h want 0/12bb56dd", er, rd); end
    endtask

    task automatic test_out_of_range();
        logic [31:0] rd; logic er, leak; int lat, n;
        sel = 0;
        xact(BASE, 1, 32'h0BAD_F00D, 4'hF, rd, er, lat, n, leak);
        vectors++; if ({lat, er} !== {32'd3, 1'b0}) begin miscompares++; $display("FAIL oor_word0_wr got lat %0d err %b want 3 0", lat, er); end
        xact(32'h7FFF_FFFC, 0, 32'h0, 4'h0, rd, er, lat, n, leak);
        vectors++; if ({lat, er, rd} !== {32'd3, 1'b1, BEEF}) begin miscompares++; $display("FAIL oor_low_rd got lat %0d %b/%h want 3 1/deadbeef", lat, er, rd); end
        xact(32'h8000_1000, 1, 32'h5555_AAAA, 4'hF, rd, er, lat, n, leak);
        vectors++; if ({lat, er, rd} !== {32'd3, 1'b1, BEEF}) begin miscompares++; $display("FAIL oor_high_wr got lat %0d %b/%h want 3 1/deadbeef", lat, er, rd); end
        xact(32'h8000_1000, 0, 32'h0, 4'h0, rd, er, lat, n, leak);
        vectors++; if ({lat, er, rd} !== {32'd3, 1'b1, BEEF}) begin miscompares++; $display("FAIL oor_high_rd got lat %0d %b/%h want 3 1/deadbeef", lat, er, rd); end
        vectors++; if (leak !== 0) begin miscompares++; $display("FAIL oor_quiet got %b want 0", leak); end
        xact(BASE, 0, 32'h0, 4'h0, rd, er, lat, n, leak);
        vectors++; if ({er, rd} !== {1'b0, 32'h0BAD_F00D}) begin miscompares++; $display("FAIL oor_word0_rd got %b/%h want 0/0badf00d", er, rd); end
    endtask

    task automatic test_zero_delay();
        logic [31:0] zd [8];
        logic [31:0] rd; logic er, leak; int lat, n;
        sel = 1;
        for (int j = 0; j < 8; j++) begin
            @(negedge clk);
            vectors++; if (ready_o !== 0) begin miscompares++; $display("FAIL zd_gap_%0d got %b want 0", j, ready_o); end
            zd[j] = $urandom;
            addr = BASE + 32'(4 * (20 + j)); wdata = zd[j]; wen = 1; wmask = 4'hF; valid = 1;
            @(posedge clk); #1;
            addr = BASE + 32'(4 * (28 + j % 4)); wdata = $urandom; wen = 0; wmask = 0;
            @(negedge clk);
            vectors++; if ({ready_o, err_o, rdata_o} !== {2'b10, 32'h0}) begin miscompares++; $display("FAIL zd_pulse_%0d got %b/%b/%h want 1/0/0", j, ready_o, err_o, rdata_o); end
        end
        valid = 0;
        for (int j = 0; j < 8; j++) begin
            xact(BASE + 32'(4 * (20 + j)), 0, 32'h0, 4'h0, rd, er, lat, n, leak);
            vectors++; if ({lat, er, rd} !== {32'd1, 1'b0, zd[j]}) begin miscompares++; $display("FAIL zd_rd_%0d got lat %0d %b/%h want 1 0/%h", j, lat, er, rd, zd[j]); end
        end
    endtask

    task automatic test_reset_mid();
        logic [31:0] rd; logic er, leak; int lat, n;
        logic seen = 0;
        sel = 2;
        xact(BASE + 12, 1, 32'hC0DE_0003, 4'hF, rd, er, lat, n, leak);
        vectors++; if (lat !== 6) begin miscompares++; $display("FAIL rm_old_wr_lat got %0d want 6", lat); end
        @(negedge clk);
        addr = BASE + 12; wen = 1; wdata = 32'hFFFF_0000; wmask = 4'hF; valid = 1;
        @(posedge clk); #1 valid = 0;
        repeat (3) @(negedge clk);
        rst = 1;
        @(posedge clk); #1 rst = 0;
        repeat (10) begin
            @(negedge clk);
            if (ready_o !== 0 || err_o !== 0 || rdata_o !== 0) seen = 1;
        end
        vectors++; if (seen !== 0) begin miscompares++; $display("FAIL rm_no_ready got %b want 0", seen); end
        xact(BASE + 12, 0, 32'h0, 4'h0, rd, er, lat, n, leak);
        vectors++; if ({lat, er, rd} !== {32'd6, 1'b0, 32'hC0DE_0003}) begin miscompares++; $display("FAIL rm_old_rd got lat %0d %b/%h want 6 0/c0de0003", lat, er, rd); end
    endtask

    task automatic test_random_delay();
        logic [31:0] sb [16];
        logic [31:0] a, d, rd, exp_rd;
        logic [7:0] s;
        logic [3:0] m;
        logic w, er, leak, oob;
        int lat, n, k, exp_lat, r;
        sel = 3;
        for (int j = 0; j < 216; j++) begin
            d = $urandom;
            if (j < 16) begin
                a = BASE + 32'(4 * j); w = 1; m = 4'hF;
            end else begin
                r = $urandom_range(0, 9);
                a = r == 0 ? BASE - 32'(4 * $urandom_range(1, 4)) :
                    r == 1 ? BASE + 32'h1000 + 32'(4 * $urandom_range(0, 3)) :
                    BASE + 32'(4 * $urandom_range(0, 15) + $urandom_range(0, 3));
                w = 1'($urandom_range(0, 1)); m = 4'($urandom_range(0, 15));
            end
            oob = a < BASE || ((a - BASE) >> 2) >= 32'd1024;
            k = oob ? 0 : int'((a - BASE) >> 2);
            exp_rd = oob ? BEEF : w ? 32'h0 : sb[k];
            xact(a, w, d, m, rd, er, lat, n, leak);
            s = lfsr_at(n);
            exp_lat = int'(s[2:0]) + 1;
            vectors++; if (!(lat >= 1 && lat <= 8)) begin miscompares++; $display("FAIL rnd_range_%0d got delay %0d want 0..7", j, lat - 1); end
            vectors++; if (lat !== exp_lat) begin miscompares++; $display("FAIL rnd_delay_%0d got %0d want %0d", j, lat - 1, exp_lat - 1); end
            vectors++; if ({er, rd} !== {oob, exp_rd}) begin miscompares++; $display("FAIL rnd_data_%0d addr %h got %b/%h want %b/%h", j, a, er, rd, oob, exp_rd); end
            vectors++; if (leak !== 0) begin miscompares++; $display("FAIL rnd_quiet_%0d got %b want 0", j, leak); end
            if (!oob && w)
                for (int b = 0; b < 4; b++)
                    if (m[b]) sb[k][8*b +: 8] = d[8*b +: 8];
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog got timeout want completion");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_fixed();
        test_byte_mask();
        test_out_of_range();
        test_zero_delay();
        test_reset_mid();
        test_random_delay();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
